truth_table_sweeper: RTL and testbench

- Self-contained characterization stage that wraps a 3-input truth-table gate module.
- Drives the gate's `in1`/`in2`/`in3` through all eight combinations 000→111, holds each one for a programmable settle time, and samples the gate's `out`.
- Assembles the observed 8-bit truth table in the same hex convention used for gate module names, and compares it against an expected value.
- Sits directly upstream of the gate under test, feeding its inputs, and directly downstream of it, consuming its output. Used in gate-library bring-up and regression.

---
 rtl/truth_table_sweeper.sv | 165 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all eight input combinations and assembles the observed truth table.
// Optional per-combination stability sampling is enabled by defining SWEEP_STABILITY_CHECK_EN.
module truth_table_sweeper #(
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [7:0]  EXPECTED      = 8'h15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       match,
   output logic [7:0] unstable
);

   // state | meaning
   // IDLE  | inputs parked at 000, waiting for start
   // SWEEP | driving code onto in1..in3, capturing dut_out every SETTLE_CYCLES cycles

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    code_q, code_d;
   logic [7:0]    shadow_q, shadow_d;
   logic [7:0]    table_q, table_d;
   logic          match_q, match_d;
   logic          done_q, done_d;

`ifdef SWEEP_STABILITY_CHECK_EN
   localparam logic [CW-1:0] CNT_EARLY = CW'(SETTLE_CYCLES - 2);
   logic          early_q, early_d;
   logic [7:0]    ushadow_q, ushadow_d;
   logic [7:0]    unstable_q, unstable_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      table_d  = table_q;
      match_d  = match_q;
      done_d   = 1'b0;
`ifdef SWEEP_STABILITY_CHECK_EN
      early_d    = early_q;
      ushadow_d  = ushadow_q;
      unstable_d = unstable_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d    = '0;
            code_d   = 3'd0;
            shadow_d = 8'h00;
`ifdef SWEEP_STABILITY_CHECK_EN
            ushadow_d = 8'h00;
`endif
            // abort outranks a coincident start
            if (start && !abort) begin
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               code_d  = 3'd0;
            end else begin
`ifdef SWEEP_STABILITY_CHECK_EN
               if (cnt_q == CNT_EARLY) begin
                  early_d = dut_out;
               end
`endif
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  shadow_d[3'd7 - code_q] = dut_out;
`ifdef SWEEP_STABILITY_CHECK_EN
                  if (dut_out != early_q) begin
                     ushadow_d[3'd7 - code_q] = 1'b1;
                  end
`endif
                  if (code_q == 3'd7) begin
                     state_d = IDLE;
                     code_d  = 3'd0;
                     table_d = shadow_d;
                     done_d  = 1'b1;
`ifdef SWEEP_STABILITY_CHECK_EN
                     unstable_d = ushadow_d;
                     match_d    = (shadow_d == EXPECTED) && (ushadow_d == 8'h00);
`else
                     match_d    = (shadow_d == EXPECTED);
`endif
                  end else begin
                     code_d = code_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         code_q   <= 3'd0;
         shadow_q <= 8'h00;
         table_q  <= 8'h00;
         match_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         shadow_q <= shadow_d;
         table_q  <= table_d;
         match_q  <= match_d;
         done_q   <= done_d;
      end
   end

`ifdef SWEEP_STABILITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         early_q    <= 1'b0;
         ushadow_q  <= 8'h00;
         unstable_q <= 8'h00;
      end else begin
         early_q    <= early_d;
         ushadow_q  <= ushadow_d;
         unstable_q <= unstable_d;
      end
   end

   assign unstable = unstable_q;
`else
   assign unstable = 8'h00;
`endif

   // code_q is forced to 000 whenever the FSM leaves SWEEP, so it drives the gate directly
   assign {in1, in2, in3} = code_q;
   assign busy            = (state_q == SWEEP);
   assign done            = done_q;
   assign table_out       = table_q;
   assign match           = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a behavioural gate model feeds dut_out,
// expected completions are queued at start and retired when done pulses.
module tb_truth_table_sweeper;

   localparam int         S   = 4;
   localparam logic [7:0] EXP = 8'h15;
   localparam int         LAT = 8 * S;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       dut_out;
   logic       in1, in2, in3;
   logic       busy, done, match;
   logic [7:0] table_out, unstable;

   int cyc = 0;
   int e0 = 0;
   int gate_sel = 0;
   bit glitch_en = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic [7:0] tbl;
      logic       m;
      logic [7:0] un;
      int         dcyc;
   } exp_t;
   exp_t sb_q[$];

   truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
      .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
      .table_out(table_out), .match(match), .unstable(unstable)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // v = {in1,in2,in3}; sel 0: in3 & (in1|in2), sel 1: 3-input AND
   function automatic logic gate(input int sel, input logic [2:0] v);
      if (sel == 0) return v[0] & (v[2] | v[1]);
      return &v;
   endfunction

   function automatic logic [7:0] model_table(input int sel);
      logic [7:0] t;
      logic [2:0] kv;
      t = 8'h00;
      for (int k = 0; k < 8; k++) begin
         kv = 3'(k);
         t[7 - k] = gate(sel, kv);
      end
      return t;
   endfunction

   assign dut_out = gate(gate_sel, {in1, in2, in3}) |
                    (glitch_en && ({in1, in2, in3} == 3'd6) && (((cyc - e0) % S) == 2));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, expv);
   endtask

   task automatic push_exp(input int sel, input logic [7:0] un, input int dcyc);
      exp_t e;
      e.tbl  = model_table(sel);
      e.un   = un;
      e.m    = (e.tbl == EXP) && (un == 8'h00);
      e.dcyc = dcyc;
      sb_q.push_back(e);
   endtask

   task automatic at_neg(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e0 = cyc;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("spurious_done", done, 1'b0);
            end else begin
               e = sb_q.pop_front();
               chk("done_cyc", cyc, e.dcyc);
               chk("table_out", table_out, e.tbl);
               chk("match", match, e.m);
               chk("unstable", unstable, e.un);
            end
         end else if (sb_q.size() > 0 && cyc > sb_q[0].dcyc) begin
            chk("done_timeout", done, 1'b1);
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_table", table_out, 0);
      chk("rst_match", match, 0);
      chk("rst_unstable", unstable, 0);
      chk("rst_in", {in1, in2, in3}, 0);
      rst_n = 1'b1;

      // abort beats start in IDLE
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      chk("abort_start_idle", busy, 0);
      start = 1'b0; abort = 1'b0;

      // full sweep, in3 & (in1|in2), with per-cycle input stepping
      gate_sel = 0;
      do_start();
      push_exp(0, 8'h00, e0 + LAT);
      for (int j = 0; j < LAT; j++) begin
         at_neg(e0 + j);
         chk("in_step", {in1, in2, in3}, j / S);
         chk("busy_sweep", busy, 1);
      end
      at_neg(e0 + LAT);
      chk("done_end", done, 1);
      chk("busy_end", busy, 0);
      chk("in_end", {in1, in2, in3}, 0);
      drain();
      @(negedge clk);
      chk("done_one_cycle", done, 0);

      // 3-input AND against 8'h15
      gate_sel = 1;
      do_start();
      push_exp(1, 8'h00, e0 + LAT);
      drain();

      gate_sel = 0;
      do_start();
      push_exp(0, 8'h00, e0 + LAT);
      drain();

      // abort mid-sweep keeps the previous result
      do_start();
      at_neg(e0 + 10);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      at_neg(e0 + 11);
      chk("abort_in", {in1, in2, in3}, 0);
      chk("abort_busy", busy, 0);
      chk("abort_table", table_out, 8'h15);
      chk("abort_match", match, 1);
      at_neg(e0 + LAT + 8);
      do_start();
      push_exp(0, 8'h00, e0 + LAT);
      drain();

      // abort on the final capture edge
      gate_sel = 1;
      do_start();
      at_neg(e0 + LAT - 1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      at_neg(e0 + LAT);
      chk("final_abort_done", done, 0);
      chk("final_abort_busy", busy, 0);
      chk("final_abort_table", table_out, 8'h15);

      // asynchronous reset mid-sweep
      gate_sel = 0;
      do_start();
      at_neg(e0 + 16);
      @(posedge clk);
      #2 rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_in", {in1, in2, in3}, 0);
      chk("arst_table", table_out, 0);
      chk("arst_match", match, 0);
      @(negedge clk);
      rst_n = 1'b1;
      gate_sel = 1;
      do_start();
      push_exp(1, 8'h00, e0 + LAT);
      at_neg(e0 + 1);
      chk("post_rst_code0", {in1, in2, in3}, 0);
      drain();

      // start held: second sweep accepted at the edge closing the done cycle
      gate_sel = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 e0 = cyc;
      push_exp(0, 8'h00, e0 + LAT);
      push_exp(0, 8'h00, e0 + 2 * LAT + 1);
      at_neg(e0 + LAT + 1);
      chk("b2b_busy", busy, 1);
      chk("b2b_in", {in1, in2, in3}, 0);
      at_neg(e0 + 2 * LAT + 1);
      start = 1'b0;
      @(negedge clk);
      chk("b2b_idle", busy, 0);
      drain();

`ifdef SWEEP_STABILITY_CHECK_EN
      gate_sel  = 0;
      glitch_en = 1'b1;
      do_start();
      push_exp(0, 8'h02, e0 + LAT);
      drain();
      glitch_en = 1'b0;
      chk("glitch_bit1", table_out[1], 0);
`endif

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
